// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    // funct3 encodings of the M-extension operations
    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } mdu_state_e;

    // Architectural results for the cases that bypass the iteration
    localparam logic [31:0] DIV0_QUOT    = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;

endpackage

// File: rtl/mdu_datapath.sv
// Combinational single-iteration step and final sign fix / result select.
// acc_i holds {hi, lo}: product halves for multiply, {remainder, quotient} for divide.
module mdu_datapath
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [2:0]              op_i,
    input  logic                    sign_a_i,
    input  logic                    sign_b_i,
    input  logic [2*DATA_WIDTH-1:0] acc_i,
    input  logic [DATA_WIDTH-1:0]   operand_i,
    output logic [2*DATA_WIDTH-1:0] acc_next_o,
    output logic [DATA_WIDTH-1:0]   result_o
);

    localparam int unsigned W = DATA_WIDTH;

    logic [W:0]     add_sum;
    logic [W:0]     rem_sh;
    logic [W+1:0]   diff;
    logic [2*W-1:0] mul_step;
    logic [2*W-1:0] div_step;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;

    // Shift-add multiply and restoring shift-subtract divide, one bit per call
    always_comb begin
        add_sum  = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, operand_i} : {(W+1){1'b0}});
        mul_step = {add_sum, acc_i[W-1:1]};
        rem_sh   = {acc_i[2*W-1:W], acc_i[W-1]};
        diff     = {1'b0, rem_sh} - {2'b00, operand_i};
        if (!diff[W+1]) begin
            div_step = {diff[W-1:0], acc_i[W-2:0], 1'b1};
        end else begin
            div_step = {rem_sh[W-1:0], acc_i[W-2:0], 1'b0};
        end
        acc_next_o = op_i[2] ? div_step : mul_step;
    end

    // Restore signs on magnitudes and pick the half the op asks for
    always_comb begin
        prod_fix = (sign_a_i ^ sign_b_i) ? -acc_i : acc_i;
        quo_fix  = (sign_a_i ^ sign_b_i) ? -acc_i[W-1:0] : acc_i[W-1:0];
        rem_fix  = sign_a_i ? -acc_i[2*W-1:W] : acc_i[2*W-1:W];
        result_o = prod_fix[W-1:0];
        unique case (op_i)
            MUL:                 result_o = prod_fix[W-1:0];
            MULH, MULHSU, MULHU: result_o = prod_fix[2*W-1:W];
            DIV, DIVU:           result_o = quo_fix;
            REM, REMU:           result_o = rem_fix;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] Result_o
);

    localparam int unsigned W = DATA_WIDTH;

    mdu_state_e            state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic                  sign_a_q, sign_a_d;
    logic                  sign_b_q, sign_b_d;
    logic [2*W-1:0]        acc_q, acc_d;
    logic [W-1:0]          bmag_q, bmag_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [W-1:0]          result_q, result_d;

    logic                  a_signed, b_signed, a_neg, b_neg;
    logic [W-1:0]          a_mag, b_mag;
    logic                  div0, ovf;
    logic [2*W-1:0]        acc_step;
    logic [W-1:0]          fixed_result;

    // Operand signedness and magnitudes from the incoming request
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        unique case (op_i)
            MUL, MULH, DIV, REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            MULHSU:  a_signed = 1'b1;
            default: ;
        endcase
        a_neg = a_signed & A_i[W-1];
        b_neg = b_signed & B_i[W-1];
        a_mag = a_neg ? -A_i : A_i;
        b_mag = b_neg ? -B_i : B_i;
        div0  = op_i[2] && (B_i == '0);
        ovf   = ((op_i == DIV) || (op_i == REM)) && (A_i == W'(OVF_DIVIDEND)) && (B_i == '1);
    end

    mdu_datapath #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_datapath (
        .op_i       (op_q),
        .sign_a_i   (sign_a_q),
        .sign_b_i   (sign_b_q),
        .acc_i      (acc_q),
        .operand_i  (bmag_q),
        .acc_next_o (acc_step),
        .result_o   (fixed_result)
    );

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_d    = acc_q;
        bmag_d   = bmag_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d     = op_i;
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    bmag_d   = b_mag;
                    acc_d    = {{W{1'b0}}, a_mag};
                    cnt_d    = '0;
                    state_d  = CALC;
                    // Special cases load the final {rem, quo} raw; cleared signs skip the fix
                    if (div0) begin
                        acc_d    = {A_i, W'(DIV0_QUOT)};
                        sign_a_d = 1'b0;
                        sign_b_d = 1'b0;
                        state_d  = FIXUP;
                    end else if (ovf) begin
                        acc_d    = {{W{1'b0}}, W'(OVF_DIVIDEND)};
                        sign_a_d = 1'b0;
                        sign_b_d = 1'b0;
                        state_d  = FIXUP;
                    end
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(W - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                result_d = fixed_result;
                state_d  = DONE;
            end
            DONE: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            bmag_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_q    <= acc_d;
            bmag_q   <= bmag_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == CALC) || (state_q == FIXUP);
    assign done_o   = (state_q == DONE);
    assign Result_o = result_q;

endmodule
